// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: selects the fetch PC (mispredict / ret / predicted),
// splits the 10 instruction bytes into icode/ifun/rA/rB/valC, computes valP
// and the status code, and runs a RUN/HALTED machine that stops fetching
// after a HLT/ADR/INS until a redirect arrives.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | fetching normally, predPC advances every unstalled cycle
// HALTED  | a fault/halt was fetched; emit nop bubbles with the held stat
//         | until a mispredict or ret redirect supplies a new fetch PC
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_stall,
    input  logic [3:0]  m_icode,
    input  logic        m_cnd,
    input  logic [63:0] m_vala,
    input  logic [3:0]  w_icode,
    input  logic [63:0] w_valm,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    output logic [2:0]  stat_f,
    output logic [3:0]  icode_f,
    output logic [3:0]  ifun_f,
    output logic [3:0]  rA_f,
    output logic [3:0]  rB_f,
    output logic [63:0] valc_f,
    output logic [63:0] valp_f
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pred_pc_q;
    logic [2:0]  hstat_q, hstat_d;
    logic        pc_load;
    logic        show_live;

    logic        mispredict, ret_redirect, redirect;
    logic [63:0] f_pc;
    logic [3:0]  raw_icode, raw_ifun;
    logic        instr_valid, need_regids;
    logic [63:0] dec_valc;
    logic [3:0]  instr_len;
    logic [64:0] end_addr;
    logic        adr_fault;
    logic [63:0] dec_valp;
    logic [63:0] next_pc;
    logic [2:0]  live_stat;

    // Fetch PC selection: a mispredicted jXX outranks a returning ret.
    always_comb begin
        mispredict   = (m_icode == I_JXX) && !m_cnd;
        ret_redirect = (w_icode == I_RET);
        redirect     = mispredict || ret_redirect;
        if (mispredict)
            f_pc = m_vala;
        else if (ret_redirect)
            f_pc = w_valm;
        else
            f_pc = pred_pc_q;
    end

    assign imem_addr = f_pc;

    // Instruction split, length, valP and fault classification.
    always_comb begin
        raw_icode   = imem_data[7:4];
        raw_ifun    = imem_data[3:0];
        instr_valid = (raw_icode <= 4'hB);

        case (raw_icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            default:                                  need_regids = 1'b0;
        endcase

        case (raw_icode)
            4'h3, 4'h4, 4'h5: dec_valc = imem_data[79:16];
            4'h7, 4'h8:       dec_valc = imem_data[71:8];
            default:          dec_valc = 64'h0;
        endcase

        case (raw_icode)
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h7, 4'h8:             instr_len = 4'd9;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            default:                instr_len = 4'd1;
        endcase

        // The bounds check uses one extra bit so a PC near 2^64 still faults,
        // while valP itself simply wraps.
        end_addr  = {1'b0, f_pc} + {61'b0, instr_len};
        adr_fault = imem_error || (end_addr > 65'(IMEM_BYTES));
        dec_valp  = f_pc + {60'b0, instr_len};

        if ((raw_icode == I_JXX) || (raw_icode == I_CALL))
            next_pc = dec_valc;
        else
            next_pc = dec_valp;

        if (adr_fault)
            live_stat = STAT_ADR;
        else if (!instr_valid)
            live_stat = STAT_INS;
        else if (raw_icode == I_HALT)
            live_stat = STAT_HLT;
        else
            live_stat = STAT_AOK;
    end

    // Next-state logic; f_stall blocks every state, hstat and predPC update.
    always_comb begin
        state_d   = state_q;
        hstat_d   = hstat_q;
        pc_load   = 1'b0;
        show_live = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (!f_stall) begin
                    pc_load = 1'b1;
                    if (live_stat != STAT_AOK) begin
                        state_d = ST_HALTED;
                        hstat_d = live_stat;
                    end
                end
            end
            ST_HALTED: begin
                // A redirect is a real fetch, so its decode is shown even while halted.
                show_live = redirect;
                if (redirect && !f_stall) begin
                    if (live_stat == STAT_AOK) begin
                        state_d = ST_RUN;
                        pc_load = 1'b1;
                    end else begin
                        hstat_d = live_stat;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output mux: live decode, or a nop bubble carrying the held stat.
    always_comb begin
        if (show_live) begin
            stat_f = live_stat;
            if (adr_fault || !instr_valid) begin
                icode_f = I_NOP;
                ifun_f  = 4'h0;
            end else begin
                icode_f = raw_icode;
                ifun_f  = raw_ifun;
            end
            rA_f   = need_regids ? imem_data[15:12] : REG_NONE;
            rB_f   = need_regids ? imem_data[11:8]  : REG_NONE;
            valc_f = dec_valc;
            valp_f = dec_valp;
        end else begin
            stat_f  = hstat_q;
            icode_f = I_NOP;
            ifun_f  = 4'h0;
            rA_f    = REG_NONE;
            rB_f    = REG_NONE;
            valc_f  = 64'h0;
            valp_f  = f_pc;
        end
    end

    // State, held status and predicted PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            hstat_q   <= STAT_AOK;
            pred_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            hstat_q <= hstat_d;
            if (pc_load)
                pred_pc_q <= next_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Useful-fetch and bubble counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if ((state_q == ST_RUN) && !f_stall && (stat_f == STAT_AOK))
                fetch_cnt <= fetch_cnt + 32'd1;
            if (f_stall || (state_q == ST_HALTED))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a byte-array instruction memory drives
// imem_data from imem_addr; each step sets inputs and compares outputs
// against hand-computed values.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        f_stall;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_vala;
    logic [3:0]  w_icode;
    logic [63:0] w_valm;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [2:0]  stat_f;
    logic [3:0]  icode_f, ifun_f, rA_f, rB_f;
    logic [63:0] valc_f, valp_f;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [0:4095];
    logic [63:0] byte_addr [0:9];

    fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(4096)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_stall    (f_stall),
        .m_icode    (m_icode),
        .m_cnd      (m_cnd),
        .m_vala     (m_vala),
        .w_icode    (w_icode),
        .w_valm     (w_valm),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .stat_f     (stat_f),
        .icode_f    (icode_f),
        .ifun_f     (ifun_f),
        .rA_f       (rA_f),
        .rB_f       (rB_f),
        .valc_f     (valc_f),
        .valp_f     (valp_f)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: out-of-range bytes read as 0.
    for (genvar g = 0; g < 10; g++) begin : g_rd
        assign byte_addr[g] = imem_addr + 64'(g);
        assign imem_data[g*8 +: 8] = (byte_addr[g] < 64'd4096) ? mem[byte_addr[g][11:0]] : 8'h00;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; f_stall = 1'b0; m_icode = 4'h0; m_cnd = 1'b0; m_vala = 64'h0;
        w_icode = 4'h0; w_valm = 64'h0; imem_error = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h10;
        // 0x00: irmovq $10,%rdx
        mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
        for (int i = 3; i < 10; i++) mem[i] = 8'h00;
        // 0x0A: jmp 0x20
        mem[10] = 8'h70; mem[11] = 8'h20;
        for (int i = 12; i < 19; i++) mem[i] = 8'h00;
        // 0x20: jmp 0x100
        mem[32] = 8'h70; mem[33] = 8'h00; mem[34] = 8'h01;
        for (int i = 35; i < 41; i++) mem[i] = 8'h00;
        mem[41]   = 8'h00;   // 0x29 halt
        mem[48]   = 8'hC0;   // 0x30 invalid
        mem[49]   = 8'hC0;   // 0x31 invalid
        mem[65]   = 8'h00;   // 0x41 halt
        mem[130]  = 8'h00;   // 0x82 halt
        mem[4095] = 8'h60;   // addq straddling the end of memory

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        chk("rst_addr",  imem_addr, 64'h0);
        chk("rst_stat",  64'(stat_f), 64'd1);
        chk("rst_icode", 64'(icode_f), 64'h3);
        chk("rst_ifun",  64'(ifun_f), 64'h0);
        chk("rst_ra",    64'(rA_f), 64'hF);
        chk("rst_rb",    64'(rB_f), 64'h2);
        chk("rst_valc",  valc_f, 64'd10);
        chk("rst_valp",  valp_f, 64'd10);
        @(negedge clk) rst_n = 1'b1;

        // Jumps and mispredict redirect
        tick();
        chk("jmp1_addr",  imem_addr, 64'h0A);
        chk("jmp1_icode", 64'(icode_f), 64'h7);
        chk("jmp1_valc",  valc_f, 64'h20);
        tick();
        chk("jmp2_valc", valc_f, 64'h100);
        chk("jmp2_valp", valp_f, 64'h29);
        tick();
        chk("pred_target", imem_addr, 64'h100);
        m_icode = 4'h7; m_cnd = 1'b0; m_vala = 64'h29;
        #1;
        chk("mispred_addr",  imem_addr, 64'h29);
        chk("halt_stat",     64'(stat_f), 64'd2);
        chk("halt_icode",    64'(icode_f), 64'h0);

        // Halted bubbles
        tick();
        m_icode = 4'h0;
        #1;
        chk("hlt_addr",  imem_addr, 64'h2A);
        chk("hlt_icode", 64'(icode_f), 64'h1);
        chk("hlt_stat",  64'(stat_f), 64'd2);
        chk("hlt_valp",  valp_f, 64'h2A);
        chk("hlt_ra",    64'(rA_f), 64'hF);
        tick();
        chk("hlt2_addr", imem_addr, 64'h2A);
        chk("hlt2_stat", 64'(stat_f), 64'd2);

        // Invalid instruction and address faults on redirect targets
        w_icode = 4'h9; w_valm = 64'h30;
        #1;
        chk("ins_stat",  64'(stat_f), 64'd4);
        chk("ins_icode", 64'(icode_f), 64'h1);
        tick();
        w_icode = 4'h0;
        #1;
        chk("ins_hstat", 64'(stat_f), 64'd4);
        chk("ins_addr",  imem_addr, 64'h2A);
        w_icode = 4'h9; w_valm = 64'hFFF;
        #1;
        chk("adr_end_stat", 64'(stat_f), 64'd3);
        tick();
        w_valm = 64'h31; imem_error = 1'b1;
        #1;
        chk("adr_over_ins", 64'(stat_f), 64'd3);
        tick();
        imem_error = 1'b0;

        // Recover at 0x40, then stall with a halt pending at 0x41
        w_valm = 64'h40;
        #1;
        chk("rec_stat", 64'(stat_f), 64'd1);
        tick();
        w_icode = 4'h0; f_stall = 1'b1;
        #1;
        chk("stall0_addr", imem_addr, 64'h41);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr",  imem_addr, 64'h41);
            chk("stall_icode", 64'(icode_f), 64'h0);
            chk("stall_stat",  64'(stat_f), 64'd2);
        end
        f_stall = 1'b0;
        tick();
        chk("hlt41_addr",  imem_addr, 64'h42);
        chk("hlt41_icode", 64'(icode_f), 64'h1);
        w_icode = 4'h9; w_valm = 64'h80;
        #1;
        chk("ret_addr", imem_addr, 64'h80);
        chk("ret_stat", 64'(stat_f), 64'd1);
        tick();
        w_icode = 4'h0;
        #1;
        chk("run80_addr", imem_addr, 64'h81);
        chk("run80_valp", valp_f, 64'h82);
        chk("run80_stat", 64'(stat_f), 64'd1);

        // Redirect priority under stall
        f_stall = 1'b1;
        m_icode = 4'h7; m_cnd = 1'b0; m_vala = 64'h50;
        w_icode = 4'h9; w_valm = 64'h60;
        #1;
        chk("prio_mispred", imem_addr, 64'h50);
        m_cnd = 1'b1;
        #1;
        chk("prio_ret", imem_addr, 64'h60);
        m_icode = 4'h0; w_icode = 4'h0;
        #1;
        chk("prio_none", imem_addr, 64'h81);
        f_stall = 1'b0;
        tick();
        tick();
        chk("hlt82_addr",  imem_addr, 64'h83);
        chk("hlt82_icode", 64'(icode_f), 64'h1);

        // valP wraps at 2^64 while the bounds check still faults
        f_stall = 1'b1; w_icode = 4'h9; w_valm = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("wrap_stat", 64'(stat_f), 64'd3);
        chk("wrap_valp", valp_f, 64'h0);
        w_icode = 4'h0; f_stall = 1'b0;

        // Mid-cycle reset while halted
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_addr",  imem_addr, 64'h0);
        chk("mrst_stat",  64'(stat_f), 64'd1);
        chk("mrst_icode", 64'(icode_f), 64'h3);
`ifdef FETCH_PERF_CNT_EN
        chk("mrst_fcnt", 64'(fetch_cnt), 64'd0);
        chk("mrst_bcnt", 64'(bubble_cnt), 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_addr", imem_addr, 64'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
